// File: rtl/layer_compositor.sv
// Two-stage priority compositor for stacked colour layers, with a sticky
// collision flag, first-hit coordinates and a per-frame collision counter.
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12,
  parameter bit KEY_BLACK  = 1'b1,
  parameter bit KEY_WHITE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    pix_row,
  input  logic [9:0]                    pix_col,
  input  logic                          video_on,
  input  logic                          frame_start,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layers_in,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          collision_ack,
  output logic [COLOR_W-1:0]            vga_out,
  output logic                          collision,
  output logic [9:0]                    coll_row,
  output logic [9:0]                    coll_col,
  output logic [7:0]                    coll_frames
);

  typedef enum logic {CLEAR, FLAGGED} coll_state_t;

  coll_state_t                   state;
  logic [NUM_LAYERS-1:0]         opaque;
  logic [NUM_LAYERS*COLOR_W-1:0] s1_layers;
  logic [NUM_LAYERS-1:0]         s1_opaque;
  logic                          s1_von;
  logic [9:0]                    s1_row;
  logic [9:0]                    s1_col;
  logic [COLOR_W-1:0]            pick;
  logic                          mid;
  logic                          hit;
  logic                          frame_hit;

  // The background layer ignores colour keying.
  always_comb begin
    opaque = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (k == NUM_LAYERS-1) begin
        opaque[k] = layer_en[k];
      end else begin
        opaque[k] = layer_en[k]
          && !(KEY_BLACK && layers_in[k*COLOR_W +: COLOR_W] == '0)
          && !(KEY_WHITE && layers_in[k*COLOR_W +: COLOR_W] == '1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_layers <= '0;
      s1_opaque <= '0;
      s1_von    <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
    end else begin
      s1_layers <= layers_in;
      s1_opaque <= opaque;
      s1_von    <= video_on;
      s1_row    <= pix_row;
      s1_col    <= pix_col;
    end
  end

  // Scan from the back so the lowest-index opaque layer wins.
  always_comb begin
    pick = '0;
    for (int k = NUM_LAYERS-1; k >= 0; k--) begin
      if (s1_opaque[k]) pick = s1_layers[k*COLOR_W +: COLOR_W];
    end
    mid = 1'b0;
    for (int k = 1; k < NUM_LAYERS-1; k++) begin
      mid = mid | s1_opaque[k];
    end
    hit = s1_von & s1_opaque[0] & mid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_out <= '0;
    end else begin
      vga_out <= s1_von ? pick : '0;
    end
  end

  // A new hit takes precedence over a simultaneous acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      coll_row <= '0;
      coll_col <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (hit) begin
            state    <= FLAGGED;
            coll_row <= s1_row;
            coll_col <= s1_col;
          end
        end
        FLAGGED: begin
          if (hit && collision_ack) begin
            coll_row <= s1_row;
            coll_col <= s1_col;
          end else if (collision_ack) begin
            state <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign collision = (state == FLAGGED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_frames <= '0;
      frame_hit   <= 1'b0;
    end else if (frame_start) begin
      if (frame_hit && coll_frames != 8'hFF) begin
        coll_frames <= coll_frames + 8'd1;
      end
      frame_hit <= hit;
    end else if (hit) begin
      frame_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: rule-level model checked every cycle plus
// hand-computed scenario checks.
module tb_layer_compositor;

  localparam int N = 4;
  localparam int W = 12;
  localparam logic [W-1:0] BG = 12'h123;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [9:0]       pix_row = '0;
  logic [9:0]       pix_col = '0;
  logic             video_on = 1'b0;
  logic             frame_start = 1'b0;
  logic [N*W-1:0]   layers_in = '0;
  logic [N-1:0]     layer_en = '0;
  logic             collision_ack = 1'b0;
  logic [W-1:0]     vga_out;
  logic             collision;
  logic [9:0]       coll_row;
  logic [9:0]       coll_col;
  logic [7:0]       coll_frames;

  int total = 0;
  int bad = 0;

  layer_compositor #(
    .NUM_LAYERS(N), .COLOR_W(W), .KEY_BLACK(1'b1), .KEY_WHITE(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .pix_row(pix_row), .pix_col(pix_col),
    .video_on(video_on), .frame_start(frame_start),
    .layers_in(layers_in), .layer_en(layer_en),
    .collision_ack(collision_ack), .vga_out(vga_out),
    .collision(collision), .coll_row(coll_row), .coll_col(coll_col),
    .coll_frames(coll_frames)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference rules: which colour shows, and does the pixel collide.
  function automatic void eval(input logic [N*W-1:0] l, input logic [N-1:0] e,
                               output logic [W-1:0] col, output logic coll);
    logic [N-1:0] op;
    logic [W-1:0] c;
    for (int k = 0; k < N; k++) begin
      c = l[k*W +: W];
      op[k] = e[k] && (k == N-1 || (c != 12'h000 && c != 12'hFFF));
    end
    col = '0;
    for (int k = 0; k < N; k++) begin
      if (op[k]) begin
        col = l[k*W +: W];
        break;
      end
    end
    coll = op[0] && (op[1] || op[2]);
  endfunction

  // Model state
  logic [W-1:0] m_pcol;
  logic         m_pcoll, m_pvon;
  logic [9:0]   m_prow, m_pc;
  logic [W-1:0] m_vga;
  logic         m_flag, m_hit, det;
  logic [9:0]   m_row, m_col;
  int           m_frames;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pcol = '0; m_pcoll = 0; m_pvon = 0; m_prow = '0; m_pc = '0;
        m_vga = '0; m_flag = 0; m_hit = 0; m_row = '0; m_col = '0;
        m_frames = 0;
      end else begin
        det = m_pvon && m_pcoll;
        m_vga = m_pvon ? m_pcol : '0;
        if (det) begin
          if (!m_flag || collision_ack) begin
            m_row = m_prow;
            m_col = m_pc;
          end
          m_flag = 1;
        end else if (collision_ack) begin
          m_flag = 0;
        end
        if (frame_start) begin
          if (m_hit && m_frames < 255) m_frames++;
          m_hit = det;
        end else if (det) begin
          m_hit = 1;
        end
        eval(layers_in, layer_en, m_pcol, m_pcoll);
        m_pvon = video_on;
        m_prow = pix_row;
        m_pc = pix_col;
      end
      @(negedge clk);
      if (!reset) begin
        chk("model_vga", vga_out, m_vga);
        chk("model_coll", collision, m_flag);
        chk("model_row", coll_row, m_row);
        chk("model_col", coll_col, m_col);
        chk("model_frames", coll_frames, m_frames);
      end
    end
  end

  task automatic px(input logic [9:0] r, c, input logic [N*W-1:0] l,
                    input logic [N-1:0] e, input logic v, fs, ak);
    pix_row = r; pix_col = c; layers_in = l; layer_en = e;
    video_on = v; frame_start = fs; collision_ack = ak;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic fs, ak);
    px(10'd0, 10'd0, pack(12'h000, 12'h000, 12'h000, BG), 4'hF, 1'b1, fs, ak);
  endtask

  task automatic hitpx(input logic [9:0] r, c);
    px(r, c, pack(12'hF00, 12'h000, 12'h00F, BG), 4'hF, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_vga", vga_out, 0);
    chk("reset_coll", collision, 0);
    chk("reset_frames", coll_frames, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    px(10'd1, 10'd1, pack(12'h000, 12'h0F0, 12'hFFF, 12'h123), 4'hF, 1, 0, 0);
    idle(0, 0);
    @(negedge clk);
    chk("s034_vga", vga_out, 12'h0F0);

    px(10'd1, 10'd2, pack(12'h000, 12'h0F0, 12'hFFF, 12'h123), 4'hD, 1, 0, 0);
    px(10'd1, 10'd3, pack(12'h000, 12'h0F0, 12'hFFF, 12'h123), 4'hD, 0, 0, 0);
    @(negedge clk);
    chk("s035_en", vga_out, 12'h123);
    idle(0, 0);
    @(negedge clk);
    chk("s035_off", vga_out, 12'h000);

    hitpx(10'd100, 10'd200);
    idle(0, 0);
    @(negedge clk);
    chk("s036_flag", collision, 1);
    chk("s036_row", coll_row, 100);
    chk("s036_col", coll_col, 200);
    hitpx(10'd300, 10'd50);
    idle(0, 0);
    @(negedge clk);
    chk("s036_keep_row", coll_row, 100);
    chk("s036_keep_col", coll_col, 200);

    hitpx(10'd10, 10'd20);
    idle(0, 1);
    @(negedge clk);
    chk("s037_flag", collision, 1);
    chk("s037_row", coll_row, 10);
    chk("s037_col", coll_col, 20);
    idle(0, 1);
    @(negedge clk);
    chk("s037_ack", collision, 0);

    idle(1, 0);
    @(negedge clk);
    chk("frames_first", coll_frames, 1);
    idle(0, 0);
    idle(1, 0);
    @(negedge clk);
    chk("frames_quiet", coll_frames, 1);
    hitpx(10'd5, 10'd6);
    idle(1, 0);
    @(negedge clk);
    chk("frames_coincide", coll_frames, 1);
    idle(1, 0);
    @(negedge clk);
    chk("frames_carry", coll_frames, 2);
    for (int f = 0; f < 300; f++) begin
      hitpx(10'(f), 10'd7);
      idle(0, 0);
      idle(1, 0);
    end
    @(negedge clk);
    chk("frames_sat", coll_frames, 255);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int f = 0; f < 7; f++) begin
      hitpx(10'd9, 10'(f));
      idle(0, 0);
      idle(1, 0);
    end
    hitpx(10'd40, 10'd41);
    @(negedge clk);
    chk("pre_rst_frames", coll_frames, 7);
    chk("pre_rst_coll", collision, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_vga", vga_out, 0);
    chk("async_coll", collision, 0);
    chk("async_row", coll_row, 0);
    chk("async_col", coll_col, 0);
    chk("async_frames", coll_frames, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    px(10'd2, 10'd2, pack(12'h000, 12'h0F0, 12'hFFF, 12'h123), 4'hF, 1, 0, 0);
    @(negedge clk);
    chk("post_rst_lat1", vga_out, 0);
    idle(0, 0);
    @(negedge clk);
    chk("post_rst_lat2", vga_out, 12'h0F0);
    idle(0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, giving the number of colour layers (range 2..8); layer 0 has the highest priority and layer NUM_LAYERS-1 is the background.
REQ-002 SHALL have parameter COLOR_W, default 12, giving the bits per pixel colour.
REQ-003 SHALL have parameter KEY_BLACK, default 1; when 1, an all-zeros colour is transparent.
REQ-004 SHALL have parameter KEY_WHITE, default 1; when 1, an all-ones colour is transparent.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pix_row  input  10  current pixel row from the timing generator.
REQ-008 SHALL have port pix_col  input  10  current pixel column from the timing generator.
REQ-009 SHALL have port video_on  input  1  active-display indicator.
REQ-010 SHALL have port frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-011 SHALL have port layers_in  input  NUM_LAYERS*COLOR_W  packed layer colours; layer k occupies bits [k*COLOR_W +: COLOR_W].
REQ-012 SHALL have port layer_en  input  NUM_LAYERS  per-layer enable.
REQ-013 SHALL have port collision_ack  input  1  clears the sticky collision flag.
REQ-014 SHALL have port vga_out  output  COLOR_W  composited pixel colour.
REQ-015 SHALL have port collision  output  1  sticky collision flag.
REQ-016 SHALL have port coll_row  output  10  row of the first collision since the flag was last cleared.
REQ-017 SHALL have port coll_col  output  10  column of the first collision since the flag was last cleared.
REQ-018 SHALL have port coll_frames  output  8  saturating count of frames that contained at least one collision.

Function
REQ-019 SHALL treat layer k (k < NUM_LAYERS-1) as opaque when layer_en[k]=1 and its colour is not a keyed transparent value; the background layer SHALL be opaque whenever layer_en[NUM_LAYERS-1]=1.
REQ-020 SHALL, in pipeline stage 1, register the layer colours, the opaque mask, video_on, pix_row and pix_col.
REQ-021 SHALL, in pipeline stage 2, drive vga_out with the colour of the lowest-index opaque layer; it SHALL drive 0 when no layer is opaque or when the staged video_on=0.
REQ-022 SHALL have a fixed latency of 2 cycles from inputs to vga_out, with one new pixel accepted every cycle and no stalls.
REQ-023 SHALL detect a collision in stage 2 when staged video_on=1, layer 0 is opaque, and any layer 1..NUM_LAYERS-2 is opaque; the background never collides.
REQ-024 SHALL, when NUM_LAYERS=2, never report a collision.
REQ-025 SHALL implement a collision FSM with two states:
- CLEAR to FLAGGED on a detected collision, latching the staged row and column into coll_row and coll_col.
- FLAGGED to CLEAR on collision_ack=1.
REQ-026 SHALL, when collision_ack=1 and a new collision occur in the same cycle, remain in or enter FLAGGED and relatch the coordinates; the new collision wins.
REQ-027 SHALL not update coll_row or coll_col while in FLAGGED, except as stated in REQ-026.
REQ-028 SHALL drive collision=1 exactly when the FSM is in FLAGGED.
REQ-029 SHALL keep an internal frame_hit bit that is set by any detected collision.
REQ-030 SHALL, on frame_start, increment coll_frames if frame_hit=1 (saturating at 255) and clear frame_hit.
REQ-031 SHALL, when a collision coincides with frame_start, count that collision toward the new frame; frame_hit ends the cycle set.

Reset
REQ-032 SHALL, on reset=1 and regardless of clk, clear vga_out, all pipeline registers, collision, coll_row, coll_col, coll_frames and frame_hit, and place the FSM in CLEAR.
REQ-033 SHALL, when reset is applied mid-frame, discard all in-flight pixels; after reset deasserts, vga_out is valid from the second rising edge.

Verification
REQ-034 SHALL pass this scenario: NUM_LAYERS=4, layers {0x000, 0x0F0, 0xFFF, 0x123}, all enabled, video_on=1 -> vga_out=0x0F0 two cycles later.
REQ-035 SHALL pass this scenario: same stimulus with layer_en=4'b1101 -> vga_out=0x123; then video_on=0 -> vga_out=0x000 two cycles later.
REQ-036 SHALL pass this scenario: layer0=0xF00, layer2=0x00F at row 100, col 200 -> collision=1 with coll_row=100 and coll_col=200; a later collision at 300/50 leaves the coordinates unchanged.
REQ-037 SHALL pass this scenario: collision_ack asserted on the same cycle as a new collision at 10/20 -> collision stays 1 and coll_row/coll_col=10/20; ack alone -> collision=0 on the next cycle.
REQ-038 SHALL pass this scenario: 300 frames, each containing a collision, with a frame_start pulse per frame -> coll_frames saturates at 255; a frame with no collision does not increment it.
REQ-039 SHALL pass this scenario: reset asserted asynchronously mid-frame with collision=1 and coll_frames=7 -> all outputs read 0 immediately, without waiting for a clock edge.
